// File: rtl/updown_counter.sv
// Parameterised up/down counter with modulo or saturating bounds.
// It provides a terminal-count flag, a one-cycle event pulse and a sticky overflow flag.
module updown_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_sticky
);

    localparam int unsigned      W1    = WIDTH + 1;
    localparam logic [W1-1:0]    MAX_E = W1'(MAX_VAL);
    localparam logic [W1-1:0]    MOD_E = MAX_E + W1'(1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [W1-1:0]    cnt_e;
    logic [W1-1:0]    step_e;
    logic [W1-1:0]    s_eff;
    logic [W1-1:0]    lv_e;
    logic [W1-1:0]    lv_eff;
    logic [W1-1:0]    sum_e;
    logic [W1-1:0]    diff_e;
    logic             ovf;
    logic             unf;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             sticky_nxt;

    // Widened arithmetic so bound comparisons never see a truncated sum
    always_comb begin
        cnt_e  = {1'b0, count_out};
        step_e = {1'b0, step};
        lv_e   = {1'b0, load_val};
        s_eff  = (step_e > MAX_E) ? MAX_E : step_e;
        lv_eff = (lv_e > MAX_E) ? MAX_E : lv_e;
        sum_e  = cnt_e + s_eff;
        ovf    = (sum_e > MAX_E);
        unf    = (s_eff > cnt_e);
        diff_e = unf ? (cnt_e + MOD_E - s_eff) : (cnt_e - s_eff);
    end

    // Priority clr > load > en
    always_comb begin
        count_nxt  = count_out;
        wrap_nxt   = 1'b0;
        sticky_nxt = ovf_sticky;
        if (clr) begin
            count_nxt  = '0;
            sticky_nxt = 1'b0;
        end else if (load) begin
            count_nxt = WIDTH'(lv_eff);
        end else if (en) begin
            if (up) begin
                if (ovf) begin
                    wrap_nxt  = 1'b1;
                    count_nxt = SATURATE ? MAX_W : WIDTH'(sum_e - MOD_E);
                end else begin
                    count_nxt = WIDTH'(sum_e);
                end
            end else begin
                if (unf) begin
                    wrap_nxt  = 1'b1;
                    count_nxt = SATURATE ? '0 : WIDTH'(diff_e);
                end else begin
                    count_nxt = WIDTH'(diff_e);
                end
            end
            sticky_nxt = ovf_sticky | wrap_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_out  <= '0;
            wrap_pulse <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            count_out  <= count_nxt;
            wrap_pulse <= wrap_nxt;
            ovf_sticky <= sticky_nxt;
        end
    end

    // Terminal count follows the live direction input with no register stage
    assign tc = up ? (count_out == MAX_W) : (count_out == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: a modulo and a saturating instance (WIDTH=4, MAX_VAL=9) are driven in lockstep.
// Each instance is checked against an integer reference model.
module tb_updown_counter;

    localparam int unsigned W   = 4;
    localparam int          MAX = 9;

    logic         clk = 1'b0;
    logic         rstn, en, up, clr, load;
    logic [W-1:0] step, load_val;
    logic [W-1:0] cnt_m, cnt_s;
    logic         tc_m, tc_s, wp_m, wp_s, st_m, st_s;

    typedef struct {
        int cnt[2];
        bit wp[2];
        bit st[2];
    } exp_t;

    exp_t q[$];
    int   m_cnt[2];
    bit   m_wp[2];
    bit   m_st[2];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(W), .MAX_VAL(9), .SATURATE(1'b0)) dut_mod (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .step(step), .clr(clr),
        .load(load), .load_val(load_val), .count_out(cnt_m), .tc(tc_m),
        .wrap_pulse(wp_m), .ovf_sticky(st_m)
    );

    updown_counter #(.WIDTH(W), .MAX_VAL(9), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .step(step), .clr(clr),
        .load(load), .load_val(load_val), .count_out(cnt_s), .tc(tc_s),
        .wrap_pulse(wp_s), .ovf_sticky(st_s)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model step for one instance
    task automatic model(input int i, input bit r, input bit c, input bit l, input int lv,
                         input bit e, input bit u, input int s);
        int t;
        int se;
        bit ev;
        ev = 1'b0;
        if (!r || c) begin
            m_cnt[i] = 0;
            m_st[i]  = 1'b0;
        end else if (l) begin
            m_cnt[i] = (lv > MAX) ? MAX : lv;
        end else if (e) begin
            se = (s > MAX) ? MAX : s;
            if (u) begin
                t = m_cnt[i] + se;
                if (t > MAX) begin
                    ev = 1'b1;
                    t  = (i == 1) ? MAX : t - (MAX + 1);
                end
            end else begin
                t = m_cnt[i] - se;
                if (t < 0) begin
                    ev = 1'b1;
                    t  = (i == 1) ? 0 : t + (MAX + 1);
                end
            end
            m_cnt[i] = t;
            if (ev) m_st[i] = 1'b1;
        end
        m_wp[i] = ev;
    endtask

    task automatic cyc(input string tag, input bit r, input bit c, input bit l, input int lv,
                       input bit e, input bit u, input int s);
        exp_t x;
        rstn     = r;
        clr      = c;
        load     = l;
        load_val = W'(lv);
        en       = e;
        up       = u;
        step     = W'(s);
        for (int i = 0; i < 2; i++) begin
            model(i, r, c, l, lv, e, u, s);
            x.cnt[i] = m_cnt[i];
            x.wp[i]  = m_wp[i];
            x.st[i]  = m_st[i];
        end
        q.push_back(x);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            x = q.pop_front();
            chk({tag, ".mod.count"}, int'(cnt_m), x.cnt[0]);
            chk({tag, ".mod.wrap"},  int'(wp_m),  int'(x.wp[0]));
            chk({tag, ".mod.stky"},  int'(st_m),  int'(x.st[0]));
            chk({tag, ".mod.tc"},    int'(tc_m),  int'(up ? (x.cnt[0] == MAX) : (x.cnt[0] == 0)));
            chk({tag, ".sat.count"}, int'(cnt_s), x.cnt[1]);
            chk({tag, ".sat.wrap"},  int'(wp_s),  int'(x.wp[1]));
            chk({tag, ".sat.stky"},  int'(st_s),  int'(x.st[1]));
            chk({tag, ".sat.tc"},    int'(tc_s),  int'(up ? (x.cnt[1] == MAX) : (x.cnt[1] == 0)));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_wp[i]  = 1'b0;
            m_st[i]  = 1'b0;
        end
        // Reset, overriding clr/load/en
        cyc("rst0", 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b1, 1);
        cyc("rst1", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 0);
        // Count up by 1 through the wrap at 9
        for (int k = 0; k < 12; k++) cyc("up1", 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1);
        // Hold with en low; the pulse drops and sticky stays
        cyc("hold", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1);
        // Underflow from 2 by 3, then clear
        cyc("ld2",   1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0, 0);
        cyc("dn3",   1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 3);
        cyc("clr",   1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        // Overflow from 8 by 5, then push past the bound again
        cyc("ld8",   1'b1, 1'b0, 1'b1, 8, 1'b0, 1'b1, 0);
        cyc("up5a",  1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 5);
        cyc("up5b",  1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 5);
        cyc("up5c",  1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 5);
        // clr beats load and en; load clamps 14 to 9
        cyc("prio",  1'b1, 1'b1, 1'b1, 5, 1'b1, 1'b1, 1);
        cyc("ld14",  1'b1, 1'b0, 1'b1, 14, 1'b0, 1'b1, 0);
        // Reset mid-count discards the step; restart from 0
        cyc("ld7",   1'b1, 1'b0, 1'b1, 7, 1'b0, 1'b1, 0);
        cyc("rstm",  1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b1, 2);
        cyc("up2",   1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 2);
        // Zero step at the upper bound keeps sticky but raises no event
        cyc("ld9a",  1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b1, 0);
        cyc("ev",    1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1);
        cyc("ld9b",  1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b1, 0);
        cyc("step0", 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0);
        // Step larger than MAX_VAL, and a direction flip
        cyc("big",   1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 15);
        cyc("flip",  1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 4);
        // Random traffic
        for (int k = 0; k < 60; k++) begin
            cyc("rnd", ($urandom_range(0, 19) != 0), ($urandom_range(0, 14) == 0),
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
